// File: rtl/edge_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : edge_scan_ctrl
// Brief    : Sequencer for an EDGE scan chain: capture, serial shift, update.
// Revision : 1.0 - initial release
// ============================================================================
module edge_scan_ctrl #(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = 8
) (
    input  logic                 CP,
    input  logic                 RN,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CHAIN_LEN-1:0] wdata,
    input  logic                 abort,
    output logic                 TE,
    output logic                 TI,
    output logic                 chain_ce,
    output logic                 en,
    input  logic                 so,
    output logic [CHAIN_LEN-1:0] rdata,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0]       c_op_shift     = 2'b00;
    localparam logic [1:0]       c_op_capture   = 2'b01;
    localparam logic [1:0]       c_op_update    = 2'b10;
    localparam logic [1:0]       c_op_shift_upd = 2'b11;
    localparam logic [CNT_W-1:0] c_last         = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_SHIFT   = 3'd2,
        S_UPDATE  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               r_state;
    logic [1:0]           r_op;
    logic [CNT_W-1:0]     r_cnt;
    logic [CHAIN_LEN-1:0] r_sreg;
    logic [CHAIN_LEN-1:0] r_rdata;
    logic                 r_te;
    logic                 r_ti;
    logic                 r_ce;
    logic                 r_en;
    logic                 r_done;
    logic                 r_busy;
    logic                 r_ready;

    // Outputs are registered from the state being entered, so each output
    // reflects the state it belongs to for the whole cycle.
    always_ff @(posedge CP or negedge RN) begin
        if (!RN) begin
            r_state <= S_IDLE;
            r_op    <= c_op_shift;
            r_cnt   <= '0;
            r_sreg  <= '0;
            r_rdata <= '0;
            r_te    <= 1'b0;
            r_ti    <= 1'b0;
            r_ce    <= 1'b0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_te    <= 1'b0;
            r_ti    <= 1'b0;
            r_ce    <= 1'b0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    if (cmd_valid && r_ready) begin
                        r_op    <= cmd_op;
                        r_sreg  <= wdata;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                        case (cmd_op)
                            c_op_capture: begin
                                r_state <= S_CAPTURE;
                                r_ce    <= 1'b1;
                            end
                            c_op_update: begin
                                r_state <= S_UPDATE;
                                r_en    <= 1'b1;
                            end
                            default: begin
                                r_state <= S_SHIFT;
                                r_te    <= 1'b1;
                                r_ce    <= 1'b1;
                                r_ti    <= wdata[0];
                            end
                        endcase
                    end
                end
                S_CAPTURE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_state <= S_SHIFT;
                        r_te    <= 1'b1;
                        r_ce    <= 1'b1;
                        r_ti    <= r_sreg[0];
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        // Partial rdata is deliberately left as shifted so far.
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_sreg  <= {1'b0, r_sreg[CHAIN_LEN-1:1]};
                        r_rdata <= {so, r_rdata[CHAIN_LEN-1:1]};
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (r_cnt == c_last) begin
                            if (r_op == c_op_shift_upd) begin
                                r_state <= S_UPDATE;
                                r_en    <= 1'b1;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_te <= 1'b1;
                            r_ce <= 1'b1;
                            r_ti <= r_sreg[1];
                        end
                    end
                end
                S_UPDATE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign TE        = r_te;
    assign TI        = r_ti;
    assign chain_ce  = r_ce;
    assign en        = r_en;
    assign rdata     = r_rdata;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
